// File: rtl/layer_sequencer.sv
// Host-side sequencer for one CNN layer: streams kernel then ifmap words into the SPADs,
// waits a fixed gap, holds route enable until the datapath finishes, and reports counts.
module layer_sequencer #(
    parameter int SRAM_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 8,
    parameter int CYC_WIDTH       = 32,
    parameter int GAP_CYCLES      = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_kernel_words,
    input  logic [ADDR_WIDTH-1:0]      i_ifmap_words,
    input  logic                       i_data_valid,
    input  logic [SRAM_DATA_WIDTH-1:0] i_data,
    output logic                       o_data_ready,
    output logic                       o_write_en,
    output logic                       o_spad_select,
    output logic [ADDR_WIDTH-1:0]      o_write_addr,
    output logic [SRAM_DATA_WIDTH-1:0] o_data_out,
    output logic [ADDR_WIDTH-1:0]      o_i_addr_end,
    output logic                       o_route_en,
    input  logic                       i_route_done,
    input  logic                       i_ofmap_valid,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output logic [ADDR_WIDTH-1:0]      o_ofmap_count,
    output logic [CYC_WIDTH-1:0]       o_cycles
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_I,
        S_GAP,
        S_ROUTE,
        S_DONE
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] kernel_words;
    logic [ADDR_WIDTH-1:0] ifmap_words;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic                  accept;
    logic                  start_ok;
    logic                  last_kernel;
    logic                  last_ifmap;
    logic                  gap_last;

    assign accept      = i_data_valid & o_data_ready;
    assign start_ok    = (state == S_IDLE) && i_start && (i_ifmap_words != '0);
    assign last_kernel = accept && (state == S_LOAD_W)
                         && (addr_cnt == kernel_words - ADDR_WIDTH'(1));
    assign last_ifmap  = accept && (state == S_LOAD_I)
                         && (addr_cnt == ifmap_words - ADDR_WIDTH'(1));
    assign gap_last    = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each combinational output gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start_ok) state_next = (i_kernel_words != '0) ? S_LOAD_W : S_LOAD_I;
            S_LOAD_W: if (last_kernel) state_next = S_LOAD_I;
            S_LOAD_I: if (last_ifmap) state_next = S_GAP;
            S_GAP:    if (gap_last) state_next = S_ROUTE;
            S_ROUTE:  if (i_route_done) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_data_ready = 1'b0;
        o_busy       = 1'b1;
        o_route_en   = 1'b0;
        o_done       = 1'b0;
        case (state)
            S_IDLE:             o_busy       = 1'b0;
            S_LOAD_W, S_LOAD_I: o_data_ready = 1'b1;
            S_ROUTE:            o_route_en   = 1'b1;
            S_DONE:             o_done       = 1'b1;
            default:            o_busy       = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            kernel_words  <= '0;
            ifmap_words   <= '0;
            addr_cnt      <= '0;
            gap_cnt       <= '0;
            o_write_en    <= 1'b0;
            o_spad_select <= 1'b0;
            o_write_addr  <= '0;
            o_data_out    <= '0;
            o_i_addr_end  <= '0;
            o_err         <= 1'b0;
            o_ofmap_count <= '0;
            o_cycles      <= '0;
        end else begin
            o_err      <= 1'b0;
            o_write_en <= accept;

            if (accept) begin
                o_data_out    <= i_data;
                o_write_addr  <= addr_cnt;
                o_spad_select <= (state == S_LOAD_I);
                // The ifmap SPAD starts at address 0 right after the last kernel word.
                addr_cnt      <= last_kernel ? '0 : addr_cnt + ADDR_WIDTH'(1);
            end

            if (state == S_IDLE && i_start) begin
                if (i_ifmap_words == '0) begin
                    o_err <= 1'b1;
                end else begin
                    kernel_words  <= i_kernel_words;
                    ifmap_words   <= i_ifmap_words;
                    o_i_addr_end  <= i_ifmap_words - ADDR_WIDTH'(1);
                    addr_cnt      <= '0;
                    o_ofmap_count <= '0;
                    o_cycles      <= '0;
                end
            end

            gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;

            if (state == S_ROUTE && o_cycles != '1) begin
                o_cycles <= o_cycles + CYC_WIDTH'(1);
            end

            if (i_ofmap_valid && (state == S_ROUTE || state == S_DONE)) begin
                o_ofmap_count <= o_ofmap_count + ADDR_WIDTH'(1);
            end
        end
    end

endmodule
